incrementer_counter: RTL and testbench

- Parametrised, registered successor to the team's 16-bit ripple incrementer.
- Holds a WIDTH-bit value and steps it by STEP on every enabled clock.
- Counts up or down, modulo a runtime limit, in either wrap or saturate mode.
- Supports synchronous load and has registered carry/borrow pulses.
- Used as the general counter/address generator in the lab datapaths; WIDTH=16, STEP=1, limit=16'hFFFF, up=1 reproduces the old incrementer with a 1-cycle latency.

---
 rtl/incrementer_counter.sv | 95 +++++++++
 tb/tb_incrementer_counter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/incrementer_counter.sv
// Registered up/down counter stepping by STEP within 0..limit,
// with wrap or saturate behaviour and one-cycle carry/borrow pulses.
module incrementer_counter #(
    parameter int          WIDTH = 16,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             bout,
    output logic             tc
);

    localparam logic [WIDTH:0] S = (WIDTH+1)'(STEP);

    logic [WIDTH:0]   qx, lx, m;
    logic [WIDTH:0]   sum, wrp, dif, brw;
    logic [WIDTH-1:0] q_nx;
    logic             c_nx, b_nx;

    // One extra bit keeps q+STEP and q+M-STEP exact before comparison.
    assign qx  = {1'b0, q};
    assign lx  = {1'b0, limit};
    assign m   = lx + 1'b1;
    assign sum = qx + S;
    assign wrp = sum - m;
    assign dif = qx - S;
    assign brw = qx + m - S;

    always_comb begin
        q_nx = q;
        c_nx = 1'b0;
        b_nx = 1'b0;
        if (load) begin
            q_nx = (din > limit) ? limit : din;
        end else if (en) begin
            if (qx > lx) begin
                // Stale count above a freshly lowered limit.
                if (up) begin
                    c_nx = 1'b1;
                    q_nx = sat ? limit : '0;
                end else begin
                    q_nx = limit;
                end
            end else if (up) begin
                if (sum <= lx) begin
                    q_nx = sum[WIDTH-1:0];
                end else begin
                    c_nx = 1'b1;
                    if (sat)
                        q_nx = limit;
                    else if (wrp > lx)
                        q_nx = '0;
                    else
                        q_nx = wrp[WIDTH-1:0];
                end
            end else begin
                if (qx >= S) begin
                    q_nx = dif[WIDTH-1:0];
                end else begin
                    b_nx = 1'b1;
                    // brw wraps to a large value when STEP > q+M.
                    if (sat)
                        q_nx = '0;
                    else if (brw > lx)
                        q_nx = limit;
                    else
                        q_nx = brw[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= '0;
            cout <= 1'b0;
            bout <= 1'b0;
        end else begin
            q    <= q_nx;
            cout <= c_nx;
            bout <= b_nx;
        end
    end

    assign tc = (up && (q == limit)) || (!up && (q == '0));

endmodule

// File: tb/tb_incrementer_counter.sv
// Bench for incrementer_counter: directed scenarios plus random stimulus
// on a 16-bit/STEP=1 and an 8-bit/STEP=3 instance against a reference model.
module tb_incrementer_counter;

    logic        clk = 1'b0;
    logic        rst_n, en, up, sat, load;
    logic [15:0] lim_a, din_a, q_a;
    logic [7:0]  lim_b, din_b, q_b;
    logic        cout_a, bout_a, tc_a;
    logic        cout_b, bout_b, tc_b;

    int checks = 0;
    int errors = 0;

    longint mq_a, mq_b;
    bit     mc_a, mb_a, mc_b, mb_b;

    always #5 clk = ~clk;

    incrementer_counter #(.WIDTH(16), .STEP(1)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat),
        .limit(lim_a), .load(load), .din(din_a),
        .q(q_a), .cout(cout_a), .bout(bout_a), .tc(tc_a)
    );

    incrementer_counter #(.WIDTH(8), .STEP(3)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat),
        .limit(lim_b), .load(load), .din(din_b),
        .q(q_b), .cout(cout_b), .bout(bout_b), .tc(tc_b)
    );

    // Reference: plain integer arithmetic on the counting rules.
    function automatic void model(
        input  longint step, lim, din, q,
        input  bit r, ld, e, u, s,
        output longint nq, output bit c, output bit b
    );
        longint m, n;
        m  = lim + 1;
        nq = q;
        c  = 0;
        b  = 0;
        if (!r) begin
            nq = 0;
        end else if (ld) begin
            nq = (din > lim) ? lim : din;
        end else if (e) begin
            if (q > lim) begin
                if (u) begin
                    c  = 1;
                    nq = s ? lim : 0;
                end else begin
                    nq = lim;
                end
            end else if (u) begin
                n = q + step;
                if (n <= lim) begin
                    nq = n;
                end else begin
                    c  = 1;
                    nq = s ? lim : ((n - m > lim) ? 0 : n - m);
                end
            end else if (q >= step) begin
                nq = q - step;
            end else begin
                b  = 1;
                n  = q + m - step;
                nq = s ? 0 : ((n < 0 || n > lim) ? lim : n);
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit r, ld, e, u, s);
        longint nq;
        bit     c, b;
        rst_n = r;
        load  = ld;
        en    = e;
        up    = u;
        sat   = s;
        @(posedge clk);
        model(1, lim_a, din_a, mq_a, r, ld, e, u, s, nq, c, b);
        mq_a = nq; mc_a = c; mb_a = b;
        model(3, lim_b, din_b, mq_b, r, ld, e, u, s, nq, c, b);
        mq_b = nq; mc_b = c; mb_b = b;
        #1;
        chk("q_a", 64'(q_a), 64'(mq_a));
        chk("cout_a", 64'(cout_a), 64'(mc_a));
        chk("bout_a", 64'(bout_a), 64'(mb_a));
        chk("tc_a", 64'(tc_a), 64'(u ? (mq_a == lim_a) : (mq_a == 0)));
        chk("q_b", 64'(q_b), 64'(mq_b));
        chk("cout_b", 64'(cout_b), 64'(mc_b));
        chk("bout_b", 64'(bout_b), 64'(mb_b));
        chk("tc_b", 64'(tc_b), 64'(u ? (mq_b == lim_b) : (mq_b == 0)));
    endtask

    initial begin
        mq_a = 0; mq_b = 0;
        lim_a = 16'hFFFF; din_a = '0;
        lim_b = 8'd9;     din_b = '0;

        // Reset with up=0: tc must be high.
        cyc(0, 0, 0, 0, 0);
        chk("rst_q", 64'(q_a), 64'h0);
        chk("rst_tc", 64'(tc_a), 64'h1);

        // 16-bit roll-over and 8-bit STEP=3 modulo-10 wrap.
        din_a = 16'hFFFE;
        cyc(1, 1, 0, 1, 0);
        cyc(1, 0, 1, 1, 0);
        chk("t1_ffff", 64'(q_a), 64'hFFFF);
        chk("t1_tc", 64'(tc_a), 64'h1);
        chk("t2_3", 64'(q_b), 64'd3);
        cyc(1, 0, 1, 1, 0);
        chk("t1_0000", 64'(q_a), 64'h0);
        chk("t1_cout", 64'(cout_a), 64'h1);
        cyc(1, 0, 1, 1, 0);
        chk("t1_0001", 64'(q_a), 64'h1);
        chk("t2_9", 64'(q_b), 64'd9);
        cyc(1, 0, 1, 1, 0);
        chk("t2_wrap", 64'(q_b), 64'd2);
        chk("t2_cout", 64'(cout_b), 64'h1);
        cyc(1, 0, 1, 1, 0);
        chk("t2_5", 64'(q_b), 64'd5);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        chk("t2_bwrap", 64'(q_b), 64'd9);
        chk("t2_bout", 64'(bout_b), 64'h1);
        cyc(1, 0, 1, 0, 0);
        chk("t2_6", 64'(q_b), 64'd6);

        // Saturation on the 8-bit counter, limit 10.
        lim_b = 8'd10; din_b = 8'd8;
        cyc(1, 1, 0, 1, 1);
        cyc(1, 0, 1, 1, 1);
        chk("t3_sat", 64'(q_b), 64'd10);
        cyc(1, 0, 1, 1, 1);
        chk("t3_hold", 64'(q_b), 64'd10);
        chk("t3_cout", 64'(cout_b), 64'h1);
        din_b = 8'd2;
        cyc(1, 1, 0, 0, 1);
        cyc(1, 0, 1, 0, 1);
        chk("t3_zero", 64'(q_b), 64'd0);
        chk("t3_bout", 64'(bout_b), 64'h1);
        chk("t3_tc", 64'(tc_b), 64'h1);
        cyc(1, 0, 1, 0, 1);

        // Load clamps to limit; load beats enable.
        lim_b = 8'd100; din_b = 8'd200;
        cyc(1, 1, 0, 1, 0);
        chk("t4_clamp", 64'(q_b), 64'd100);
        din_b = 8'd7;
        cyc(1, 1, 1, 1, 0);
        chk("t4_ld_en", 64'(q_b), 64'd7);

        // Limit lowered below the current count.
        din_b = 8'd50;
        cyc(1, 1, 0, 1, 0);
        lim_b = 8'd20;
        cyc(1, 0, 1, 1, 0);
        chk("t5_up", 64'(q_b), 64'd0);
        chk("t5_cout", 64'(cout_b), 64'h1);
        lim_b = 8'd100;
        cyc(1, 1, 0, 1, 0);
        lim_b = 8'd20;
        cyc(1, 0, 1, 0, 0);
        chk("t5_dn", 64'(q_b), 64'd20);

        // Reset while stepping and loading.
        lim_a = 16'hFFFF; din_a = 16'h1232;
        cyc(1, 1, 0, 1, 0);
        cyc(1, 0, 1, 1, 0);
        cyc(1, 0, 1, 1, 0);
        chk("t6_1234", 64'(q_a), 64'h1234);
        cyc(0, 1, 1, 1, 0);
        chk("t6_rst", 64'(q_a), 64'h0);
        cyc(1, 0, 1, 1, 0);
        chk("t6_resume", 64'(q_a), 64'h1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0)
                lim_a = ($urandom_range(0, 3) == 0) ?
                        16'($urandom_range(0, 20)) : 16'($urandom);
            if ($urandom_range(0, 15) == 0)
                lim_b = 8'($urandom_range(0, 255));
            din_a = 16'($urandom);
            din_b = 8'($urandom);
            cyc($urandom_range(0, 40) != 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 3) != 0,
                1'($urandom),
                1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
